// File: rtl/oh_fifo_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : oh_fifo_sync_ctrl
// Purpose : Single-clock FIFO controller and storage with occupancy, flags and
//           sticky overflow/underflow error reporting.
// Revision: 1.0 - initial release
// ============================================================================
module oh_fifo_sync_ctrl #(
  parameter int DW        = 104,
  parameter int DEPTH     = 32,
  parameter int AW        = 5,
  parameter int PROG_FULL = 28
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic          prog_full,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          valid,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW:0] c_depth     = (AW+1)'(DEPTH);
  localparam logic [AW:0] c_prog_full = (AW+1)'(PROG_FULL);
  localparam logic [AW:0] c_one       = (AW+1)'(1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_prog_full;
  logic [DW-1:0] r_dout;
  logic          r_valid;
  logic          r_overflow;
  logic          r_underflow;

  logic          w_wr_acc;
  logic          w_rd_acc;
  logic [AW:0]   w_count_nxt;

  // Flags come from start-of-cycle state, so read-while-full and
  // write-while-empty each accept only one side.
  assign w_wr_acc = wr_en & ~r_full;
  assign w_rd_acc = rd_en & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_acc && !w_rd_acc) begin
      w_count_nxt = r_count + c_one;
    end else if (!w_wr_acc && w_rd_acc) begin
      w_count_nxt = r_count - c_one;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_prog_full <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + c_one;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + c_one;
      end
      r_count     <= w_count_nxt;
      r_full      <= (w_count_nxt == c_depth);
      r_empty     <= (w_count_nxt == '0);
      r_prog_full <= (w_count_nxt >= c_prog_full);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_dout <= r_mem[r_rd_ptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && r_full) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && r_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign full      = r_full;
  assign empty     = r_empty;
  assign prog_full = r_prog_full;
  assign count     = r_count;
  assign dout      = r_dout;
  assign valid     = r_valid;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule
`default_nettype wire
